wb_uart_slave: RTL and testbench
================================

# wb_uart_slave

Wishbone classic slave implementing the UART peripheral in the 0x0100_0000–0x0100_000F window. Responds to the CYC/STB strobes routed by the data-side interconnect and returns DAT/ACK/ERR to it. Contains one 8N1 transmitter, one 8N1 receiver and a programmable baud divisor. Only address bits [3:0] are decoded; upper-bit selection is done upstream.

## Interface
- WISHBONE_ADDR_WIDTH, 32, address bus width
- WISHBONE_BUS_WIDTH, 32, data bus width (must be 32)
- DEFAULT_DIV, 16'd868, divisor reset value, in clock cycles per bit (100 MHz / 115200)
- CLK_I  in  1  single clock; everything is sampled on its rising edge
- RST_NI  in  1  asynchronous, active-low reset
- WBS_CYC_I  in  1  bus cycle
- WBS_STB_I  in  1  strobe
- WBS_ADR_I  in  WISHBONE_ADDR_WIDTH  byte address; only [3:0] are used
- WBS_WE_I  in  1  write enable
- WBS_DAT_I  in  WISHBONE_BUS_WIDTH  write data
- WBS_SEL_I  in  WISHBONE_BUS_WIDTH/8  byte selects
- WBS_DAT_O  out  WISHBONE_BUS_WIDTH  read data
- WBS_ACK_O  out  1  normal termination
- WBS_ERR_O  out  1  error termination
- UART_TX  out  1  serial output, idle high
- UART_RX  in  1  serial input, asynchronous to CLK_I

## Operation
- **Register map (ADR[3:0])**
  - 0x0 TXDATA, write-only: a write with SEL[0]=1 loads DAT_I[7:0] and starts a frame.
    - A write while tx_busy=1 returns ERR and leaves the frame in flight untouched.
    - A read returns 0 with ACK.
  - 0x4 RXDATA, read-only: returns {24'b0, rx_byte} and clears rx_valid, rx_overrun and rx_frame_err.
  - 0x8 STATUS, read-only:
    - bit0 tx_busy
    - bit1 rx_valid
    - bit2 rx_overrun (sticky)
    - bit3 rx_frame_err (sticky)
    - other bits read 0
  - 0xC DIV, read/write, bits[15:0].
    - A write with a value below 4 returns ERR and leaves DIV unchanged.
    - A write uses SEL[1:0]; both must be 1, otherwise ERR.
- **Errors (ERR instead of ACK)**
  - ADR[1:0] != 0.
  - Write to RXDATA or STATUS.
  - Any of the TXDATA and DIV error cases above.
- **Transmitter**: states IDLE → START → DATA → STOP → IDLE.
  - DIV is latched at frame start; a DIV write mid-frame applies to the next frame.
  - Each bit lasts exactly DIV cycles. Data goes out LSB first. One stop bit.
  - tx_busy=1 from the cycle after the accepting ACK until the end of the stop bit.
- **Receiver**: UART_RX passes through a 2-flop synchronizer. States IDLE → START → DATA → STOP.
  - IDLE → START on a synchronized falling edge.
  - In START, resample after DIV/2 (integer division). If low, go to DATA; if high, treat as a glitch and return to IDLE.
  - In DATA, sample every DIV cycles, 8 bits, LSB first.
  - In STOP, sample after DIV cycles, then return to IDLE.
    - Stop bit = 1: the byte is stored in rx_byte and rx_valid is set.
    - Stop bit = 0: the byte is discarded and rx_frame_err is set.
  - A byte completing while rx_valid=1 is dropped, rx_byte keeps the old value, and rx_overrun is set.
  - A byte completing in the same cycle as an RXDATA read's ACK: the new byte is stored, rx_valid stays 1, and no overrun is flagged.

## Timing
- **Reset values**
  - WBS_ACK_O=0, WBS_ERR_O=0, WBS_DAT_O=0, UART_TX=1.
  - DIV=DEFAULT_DIV; rx_byte=0; all flags=0; both FSMs in IDLE.
- **Bus handshake**
  - A request is CYC&STB while ACK=0 and ERR=0.
  - ACK or ERR is registered and is high for exactly one cycle, on the cycle after the request. WBS_DAT_O is valid in that same cycle.
  - Holding STB across the ACK cycle does not create a second access. The next access needs STB sampled high after the ACK/ERR cycle.
  - Side effects (TX start, RX flag clear, DIV update) occur once per access, at the clock edge that raises ACK.
- **Serial latency**
  - UART_TX falls 1 cycle after ACK of the TXDATA write.
  - A full frame is 10×DIV cycles.
- **Receive latency**
  - rx_valid rises 2 sync cycles + DIV/2 + 9×DIV cycles after the RX falling edge, ±1 cycle.
- **Reset**
  - Reset asserted mid-frame forces UART_TX=1 and clears ACK/ERR immediately (asynchronously).
  - A frame in progress is abandoned and is not resumed after reset releases.

## Test plan
- TX, DIV=4: write 0x55 to 0x0 → ACK 1 cycle later; UART_TX shows 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles; STATUS bit0 reads 1 during the frame and 0 after 40 cycles.
- TX busy: a second TXDATA write (0xAA) 5 cycles into the frame → ERR; the 0x55 waveform is unchanged; no 0xAA frame follows.
- RX, DIV=8: drive 0xA5 at 8 cycles/bit → STATUS reads 0x2; RXDATA reads 0x000000A5; STATUS then reads 0x0.
- RX faults:
  - Send two bytes without reading → STATUS reads 0x6 and RXDATA returns the first byte.
  - A frame with stop bit = 0 → bit3 set and rx_valid unchanged.
- Bus errors, each → ERR with no state change:
  - read of 0x2;
  - write to 0x8;
  - DIV write of 3.
  - A DIV write of 10 then a read of 0xC → 0x0000000A.
- Reset mid-frame: assert RST_NI low in the middle of a TX data bit → UART_TX=1 the same cycle; after release, DIV=868 and STATUS=0.

Source files
------------

// File: rtl/wb_uart_slave_if.sv
// rtl/wb_uart_slave_if.sv - Wishbone classic bus bundle between the data-side interconnect and the UART slave
// Signals (slave view):
//   WBS_CYC_I/WBS_STB_I  bus cycle and strobe
//   WBS_ADR_I            byte address, slave decodes [3:0] only
//   WBS_WE_I             write enable
//   WBS_DAT_I/WBS_SEL_I  write data and byte selects
//   WBS_DAT_O            read data, valid in the ACK cycle
//   WBS_ACK_O/WBS_ERR_O  one-cycle normal / error termination
interface wb_uart_slave_if #(
    parameter int WISHBONE_ADDR_WIDTH = 32,
    parameter int WISHBONE_BUS_WIDTH  = 32
);
    logic                              WBS_CYC_I;
    logic                              WBS_STB_I;
    logic [WISHBONE_ADDR_WIDTH-1:0]    WBS_ADR_I;
    logic                              WBS_WE_I;
    logic [WISHBONE_BUS_WIDTH-1:0]     WBS_DAT_I;
    logic [WISHBONE_BUS_WIDTH/8-1:0]   WBS_SEL_I;
    logic [WISHBONE_BUS_WIDTH-1:0]     WBS_DAT_O;
    logic                              WBS_ACK_O;
    logic                              WBS_ERR_O;

    modport master (
        output WBS_CYC_I, WBS_STB_I, WBS_ADR_I, WBS_WE_I, WBS_DAT_I, WBS_SEL_I,
        input  WBS_DAT_O, WBS_ACK_O, WBS_ERR_O
    );

    modport slave (
        input  WBS_CYC_I, WBS_STB_I, WBS_ADR_I, WBS_WE_I, WBS_DAT_I, WBS_SEL_I,
        output WBS_DAT_O, WBS_ACK_O, WBS_ERR_O
    );
endinterface

// File: rtl/wb_uart_slave.sv
// rtl/wb_uart_slave.sv - Wishbone classic UART slave: 8N1 transmitter, 8N1 receiver, programmable baud divisor
// Ports:
//   CLK_I    single clock, rising edge
//   RST_NI   asynchronous active-low reset
//   wbs      Wishbone slave bundle (wb_uart_slave_if.slave)
//   UART_TX  serial output, idle high
//   UART_RX  serial input, asynchronous to CLK_I
// Registers (ADR[3:0]): 0x0 TXDATA (W), 0x4 RXDATA (R), 0x8 STATUS (R), 0xC DIV (R/W)
module wb_uart_slave #(
    parameter int          WISHBONE_ADDR_WIDTH = 32,
    parameter int          WISHBONE_BUS_WIDTH  = 32,
    parameter logic [15:0] DEFAULT_DIV         = 16'd868
) (
    input  logic                  CLK_I,
    input  logic                  RST_NI,
    wb_uart_slave_if.slave        wbs,
    output logic                  UART_TX,
    input  logic                  UART_RX
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // bus side
    logic                          r_ack;
    logic                          r_err;
    logic [WISHBONE_BUS_WIDTH-1:0] r_dat;
    logic [15:0]                   r_div;
    logic                          r_tx_go;
    logic [7:0]                    r_tx_data;

    // transmitter
    state_t      r_tx_state;
    logic        r_tx;
    logic        r_tx_busy;
    logic [15:0] r_tx_cnt;
    logic [15:0] r_tx_div;
    logic [7:0]  r_tx_shift;
    logic [2:0]  r_tx_bit;

    // receiver
    state_t      r_rx_state;
    logic        r_rx_s1, r_rx_s2, r_rx_s3;
    logic [15:0] r_rx_cnt;
    logic [15:0] r_rx_div;
    logic [7:0]  r_rx_shift;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_byte;
    logic        r_rx_valid;
    logic        r_rx_ovr;
    logic        r_rx_ferr;

    logic                          w_req;
    logic                          w_acc;
    logic [3:0]                    w_adr;
    logic                          w_err;
    logic                          w_tx_start;
    logic                          w_div_wr;
    logic                          w_rx_clr;
    logic [WISHBONE_BUS_WIDTH-1:0] w_rdata;
    logic                          w_tx_end;
    logic                          w_rx_end;
    logic                          w_rx_half;
    logic                          w_rx_fall;
    logic                          w_unused;

    assign w_unused = ^{wbs.WBS_ADR_I[WISHBONE_ADDR_WIDTH-1:4],
                        wbs.WBS_DAT_I[WISHBONE_BUS_WIDTH-1:16],
                        wbs.WBS_SEL_I[WISHBONE_BUS_WIDTH/8-1:2]};

    // ACK/ERR high blocks a new request, so a strobe held through the
    // termination cycle is not taken as a second access.
    assign w_req = wbs.WBS_CYC_I & wbs.WBS_STB_I & ~r_ack & ~r_err;
    assign w_acc = w_req & ~w_err;
    assign w_adr = wbs.WBS_ADR_I[3:0];

    always_comb begin
        w_err      = 1'b0;
        w_tx_start = 1'b0;
        w_div_wr   = 1'b0;
        w_rx_clr   = 1'b0;
        w_rdata    = '0;
        if (w_adr[1:0] != 2'b00) begin
            w_err = 1'b1;
        end else begin
            case (w_adr[3:2])
                2'd0: begin
                    if (wbs.WBS_WE_I) begin
                        // r_tx_go covers the cycle between ACK and the FSM leaving IDLE
                        if (r_tx_busy | r_tx_go) w_err = 1'b1;
                        else                     w_tx_start = wbs.WBS_SEL_I[0];
                    end
                end
                2'd1: begin
                    if (wbs.WBS_WE_I) begin
                        w_err = 1'b1;
                    end else begin
                        w_rdata[7:0] = r_rx_byte;
                        w_rx_clr     = 1'b1;
                    end
                end
                2'd2: begin
                    if (wbs.WBS_WE_I) w_err = 1'b1;
                    else              w_rdata[3:0] = {r_rx_ferr, r_rx_ovr, r_rx_valid, r_tx_busy};
                end
                default: begin
                    if (wbs.WBS_WE_I) begin
                        if (wbs.WBS_SEL_I[1:0] != 2'b11 || wbs.WBS_DAT_I[15:0] < 16'd4) w_err = 1'b1;
                        else                                                             w_div_wr = 1'b1;
                    end else begin
                        w_rdata[15:0] = r_div;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_dat     <= '0;
            r_div     <= DEFAULT_DIV;
            r_tx_go   <= 1'b0;
            r_tx_data <= 8'd0;
        end else begin
            r_ack   <= w_acc;
            r_err   <= w_req & w_err;
            r_dat   <= w_acc ? w_rdata : '0;
            r_tx_go <= w_acc & w_tx_start;
            if (w_acc & w_tx_start) r_tx_data <= wbs.WBS_DAT_I[7:0];
            if (w_acc & w_div_wr)   r_div     <= wbs.WBS_DAT_I[15:0];
        end
    end

    assign wbs.WBS_ACK_O = r_ack;
    assign wbs.WBS_ERR_O = r_err;
    assign wbs.WBS_DAT_O = r_dat;

    // Transmitter: divisor is captured when the frame starts.
    assign w_tx_end = (r_tx_cnt == r_tx_div - 16'd1);

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_tx_state <= S_IDLE;
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_cnt   <= 16'd0;
            r_tx_div   <= 16'd0;
            r_tx_shift <= 8'd0;
            r_tx_bit   <= 3'd0;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    if (r_tx_go) begin
                        r_tx_state <= S_START;
                        r_tx       <= 1'b0;
                        r_tx_busy  <= 1'b1;
                        r_tx_cnt   <= 16'd0;
                        r_tx_div   <= r_div;
                        r_tx_shift <= r_tx_data;
                    end
                end
                S_START: begin
                    if (w_tx_end) begin
                        r_tx_cnt   <= 16'd0;
                        r_tx_bit   <= 3'd0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_state <= S_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_tx_end) begin
                        r_tx_cnt <= 16'd0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= S_STOP;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx       <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (w_tx_end) begin
                        r_tx_state <= S_IDLE;
                        r_tx_busy  <= 1'b0;
                        r_tx_cnt   <= 16'd0;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    assign UART_TX = r_tx;

    // Receiver: r_rx_s3 is only the previous synchronized value for edge detection.
    assign w_rx_fall = r_rx_s3 & ~r_rx_s2;
    assign w_rx_end  = (r_rx_cnt == r_rx_div - 16'd1);
    assign w_rx_half = (r_rx_cnt == (r_rx_div >> 1) - 16'd1);

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_div   <= 16'd0;
            r_rx_shift <= 8'd0;
            r_rx_bit   <= 3'd0;
            r_rx_byte  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_s1 <= UART_RX;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;

            // A read clears the flags first; a byte landing on the same edge
            // then re-sets them below, so the read never causes an overrun.
            if (w_acc & w_rx_clr) begin
                r_rx_valid <= 1'b0;
                r_rx_ovr   <= 1'b0;
                r_rx_ferr  <= 1'b0;
            end

            case (r_rx_state)
                S_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= S_START;
                        r_rx_cnt   <= 16'd0;
                        r_rx_div   <= r_div;
                    end
                end
                S_START: begin
                    if (w_rx_half) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_bit   <= 3'd0;
                        r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_rx_end) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
                        else                  r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (w_rx_end) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_state <= S_IDLE;
                        if (r_rx_s2) begin
                            if (!r_rx_valid || (w_acc & w_rx_clr)) begin
                                r_rx_byte  <= r_rx_shift;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_rx_ovr <= 1'b1;
                            end
                        end else begin
                            r_rx_ferr <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart_slave.sv
// tb/tb_wb_uart_slave.sv - directed self-checking bench for wb_uart_slave
module tb_wb_uart_slave;

    localparam logic [1:0] R_ACK = 2'b10;
    localparam logic [1:0] R_ERR = 2'b01;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_uart_slave_if wb ();

    wb_uart_slave #(
        .WISHBONE_ADDR_WIDTH (32),
        .WISHBONE_BUS_WIDTH  (32),
        .DEFAULT_DIV         (16'd868)
    ) dut (
        .CLK_I   (clk),
        .RST_NI  (rst_n),
        .wbs     (wb),
        .UART_TX (uart_tx),
        .UART_RX (uart_rx)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_drive(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb.WBS_CYC_I = 1'b1;
        wb.WBS_STB_I = 1'b1;
        wb.WBS_WE_I  = we;
        wb.WBS_ADR_I = adr;
        wb.WBS_DAT_I = dat;
        wb.WBS_SEL_I = sel;
    endtask

    task automatic bus_idle();
        wb.WBS_CYC_I = 1'b0;
        wb.WBS_STB_I = 1'b0;
        wb.WBS_WE_I  = 1'b0;
    endtask

    // One access: request driven at a negedge, termination sampled one cycle later.
    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       output logic [33:0] res);
        @(negedge clk);
        bus_drive(we, adr, dat, sel);
        @(negedge clk);
        res = {wb.WBS_ACK_O, wb.WBS_ERR_O, wb.WBS_DAT_O};
        bus_idle();
    endtask

    task automatic bus_chk(input string tag, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [1:0] term, input logic [31:0] exp_dat);
        logic [33:0] r;
        bus(we, adr, dat, sel, r);
        chk(tag, {30'd0, r}, {30'd0, term, exp_dat});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (div) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        logic [33:0] r;
        logic [47:0] obs;
        logic        low_seen;

        wb.WBS_ADR_I = '0;
        wb.WBS_DAT_I = '0;
        wb.WBS_SEL_I = '0;
        bus_idle();

        repeat (3) @(negedge clk);
        chk("rst_tx", {63'd0, uart_tx}, 64'd1);
        chk("rst_ack_err", {62'd0, wb.WBS_ACK_O, wb.WBS_ERR_O}, 64'd0);
        chk("rst_dat", {32'd0, wb.WBS_DAT_O}, 64'd0);
        rst_n = 1'b1;

        bus_chk("rst_div", 1'b0, 32'hC, 32'd0, 4'hF, R_ACK, 32'h364);
        bus_chk("rst_status", 1'b0, 32'h8, 32'd0, 4'hF, R_ACK, 32'h0);
        bus_chk("rst_rxdata", 1'b0, 32'h4, 32'd0, 4'hF, R_ACK, 32'h0);

        // TX at DIV=4 with a colliding TXDATA write and an in-frame STATUS read
        bus_chk("div_wr4", 1'b1, 32'hC, 32'd4, 4'hF, R_ACK, 32'h0);
        bus(1'b1, 32'h0, 32'h55, 4'hF, r);
        chk("tx_wr_ack", {30'd0, r}, {30'd0, R_ACK, 32'h0});
        chk("tx_idle_in_ack", {63'd0, uart_tx}, 64'd1);
        obs = '0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            obs[i] = uart_tx;
            if (i == 3) bus_drive(1'b1, 32'h0, 32'hAA, 4'hF);
            if (i == 4) begin
                chk("tx_busy_err", {62'd0, wb.WBS_ACK_O, wb.WBS_ERR_O}, {62'd0, R_ERR});
                bus_idle();
            end
            if (i == 10) bus_drive(1'b0, 32'h8, 32'h0, 4'hF);
            if (i == 11) begin
                chk("tx_busy_status", {30'd0, wb.WBS_ACK_O, wb.WBS_ERR_O, wb.WBS_DAT_O},
                    {30'd0, R_ACK, 32'h1});
                bus_idle();
            end
        end
        chk("tx_wave_55", {16'd0, obs}, {16'd0, 48'hFF_F0F0F0F0F0});
        bus_chk("tx_done_status", 1'b0, 32'h8, 32'd0, 4'hF, R_ACK, 32'h0);
        bus_chk("txdata_read", 1'b0, 32'h0, 32'd0, 4'hF, R_ACK, 32'h0);

        // RX at DIV=8
        bus_chk("div_wr8", 1'b1, 32'hC, 32'd8, 4'hF, R_ACK, 32'h0);
        send_byte(8'hA5, 1'b1, 8);
        repeat (2) @(negedge clk);
        bus_chk("rx_status_valid", 1'b0, 32'h8, 32'd0, 4'hF, R_ACK, 32'h2);
        bus_chk("rx_data_a5", 1'b0, 32'h4, 32'd0, 4'hF, R_ACK, 32'hA5);
        bus_chk("rx_status_clr", 1'b0, 32'h8, 32'd0, 4'hF, R_ACK, 32'h0);

        send_byte(8'h3C, 1'b1, 8);
        send_byte(8'hC3, 1'b1, 8);
        repeat (2) @(negedge clk);
        bus_chk("rx_overrun_status", 1'b0, 32'h8, 32'd0, 4'hF, R_ACK, 32'h6);
        bus_chk("rx_overrun_first", 1'b0, 32'h4, 32'd0, 4'hF, R_ACK, 32'h3C);
        bus_chk("rx_overrun_clr", 1'b0, 32'h8, 32'd0, 4'hF, R_ACK, 32'h0);

        send_byte(8'h5A, 1'b1, 8);
        send_byte(8'h11, 1'b0, 8);
        repeat (2) @(negedge clk);
        bus_chk("rx_ferr_status", 1'b0, 32'h8, 32'd0, 4'hF, R_ACK, 32'hA);
        bus_chk("rx_ferr_keep", 1'b0, 32'h4, 32'd0, 4'hF, R_ACK, 32'h5A);
        bus_chk("rx_ferr_clr", 1'b0, 32'h8, 32'd0, 4'hF, R_ACK, 32'h0);

        // Bus error terminations
        bus_chk("err_rd_adr2", 1'b0, 32'h2, 32'd0, 4'hF, R_ERR, 32'h0);
        bus_chk("err_wr_status", 1'b1, 32'h8, 32'hF, 4'hF, R_ERR, 32'h0);
        bus_chk("err_wr_rxdata", 1'b1, 32'h4, 32'hF, 4'hF, R_ERR, 32'h0);
        bus_chk("err_status_same", 1'b0, 32'h8, 32'd0, 4'hF, R_ACK, 32'h0);
        bus_chk("err_div3", 1'b1, 32'hC, 32'd3, 4'hF, R_ERR, 32'h0);
        bus_chk("err_div_sel", 1'b1, 32'hC, 32'd10, 4'h1, R_ERR, 32'h0);
        bus_chk("div_unchanged", 1'b0, 32'hC, 32'd0, 4'hF, R_ACK, 32'h8);
        bus_chk("div_wr10", 1'b1, 32'hC, 32'd10, 4'h3, R_ACK, 32'h0);
        bus_chk("div_rd10", 1'b0, 32'hC, 32'd0, 4'hF, R_ACK, 32'hA);

        // Reset in the middle of data bit 0 of a 0x00 frame at DIV=10
        bus_chk("tx_wr_00", 1'b1, 32'h0, 32'h00, 4'hF, R_ACK, 32'h0);
        repeat (15) @(negedge clk);
        chk("tx_mid_data_low", {63'd0, uart_tx}, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx", {63'd0, uart_tx}, 64'd1);
        chk("rst_async_ack_err", {62'd0, wb.WBS_ACK_O, wb.WBS_ERR_O}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        low_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) low_seen = 1'b1;
        end
        chk("rst_no_resume", {63'd0, low_seen}, 64'd0);
        bus_chk("rst2_div", 1'b0, 32'hC, 32'd0, 4'hF, R_ACK, 32'h364);
        bus_chk("rst2_status", 1'b0, 32'h8, 32'd0, 4'hF, R_ACK, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
